rx_lane_sched: RTL and testbench
================================

RX_LANE_SCHED -- requirements
Module: rx_lane_sched

Interface
REQ-001 SHALL have parameter COMMA, default 8'hBC: comma/sync symbol value.
REQ-002 SHALL have parameter SYNC_CNT, default 4: consecutive commas needed to reach ACTIVE.
REQ-003 SHALL have parameter LOSS_CNT, default 4: consecutive errored bytes that drop ACTIVE.
REQ-004 SHALL have port clk_32f  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset_L  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port byte_in  input  8  aligned byte from the serial-to-parallel stage.
REQ-007 SHALL have port byte_stb  input  1  byte_in valid this cycle; any rate, including back-to-back.
REQ-008 SHALL have port sym_err  input  1  byte_in is errored; sampled only with byte_stb.
REQ-009 SHALL have ports out0..out3  output  8 each  lane data registers.
REQ-010 SHALL have ports val_out0..val_out3  output  1 each  one-cycle lane-valid pulses.
REQ-011 SHALL have port active  output  1  high in ACTIVE state.
REQ-012 SHALL have port lane_ptr  output  2  next lane to receive data.
REQ-013 SHALL have port sync_lost  output  1  one-cycle pulse on the ACTIVE->HUNT transition.

Function
REQ-014 SHALL implement two states, HUNT and ACTIVE; only byte_stb-qualified cycles affect counters, pointer or state.
REQ-015 In HUNT, a strobed byte equal to COMMA with sym_err=0 SHALL increment bc_cnt, saturating at SYNC_CNT.
REQ-016 In HUNT, any other strobed byte, including COMMA with sym_err=1, SHALL clear bc_cnt to 0.
REQ-017 The strobe that brings bc_cnt to SYNC_CNT SHALL move HUNT->ACTIVE, so active=1 the next cycle, with lane_ptr=0 and err_cnt=0.
REQ-018 In HUNT, no val_outN SHALL assert, and out0..out3 SHALL hold their values.
REQ-019 In ACTIVE, a strobed byte with sym_err=0 and byte_in!=COMMA SHALL be written to out[lane_ptr], with val_out[lane_ptr]=1 for exactly the next cycle.
REQ-020 In the same ACTIVE case, lane_ptr SHALL increment modulo 4 (3 wraps to 0) and err_cnt SHALL clear.
REQ-021 Latency from a byte_stb cycle to its val_outN pulse SHALL be exactly 1 clock; at most one val_outN SHALL be high per cycle.
REQ-022 In ACTIVE, a strobed COMMA with sym_err=0 SHALL not be forwarded, SHALL force lane_ptr to 0 (lane realignment) and SHALL clear err_cnt.
REQ-023 In ACTIVE, a strobed byte with sym_err=1 SHALL not be forwarded, SHALL increment lane_ptr modulo 4 and SHALL increment err_cnt; sym_err has priority over the comma check.
REQ-024 When err_cnt reaches LOSS_CNT, the SHALL go ACTIVE->HUNT: active=0 and sync_lost=1 for one cycle on the next clock, with bc_cnt, err_cnt and lane_ptr cleared.
REQ-025 out0..out3 SHALL hold their last value when the corresponding val_outN is low.
REQ-026 byte_stb=0 cycles SHALL leave all state unchanged, and val_out0..val_out3 and sync_lost SHALL be 0 in them.

Reset
REQ-027 reset_L=0 SHALL immediately force state HUNT, with no clock edge required.
REQ-028 The same reset SHALL force bc_cnt=0, err_cnt=0, lane_ptr=0, out0..out3=8'h00, all val_outN=0, active=0 and sync_lost=0.
REQ-029 Reset asserted mid-transfer SHALL discard any in-flight byte: no val_outN pulse after reset_L falls.
REQ-030 Operation SHALL resume at the first rising edge of clk_32f with reset_L=1.

Verification
REQ-031 Sync acquisition: 4 strobes of 8'hBC -> active=1 one cycle after the 4th; then AB,AB,AB,AB,AB -> val_out0,1,2,3,0 pulse in order, all out=8'hAB, lane_ptr ends at 1.
REQ-032 No sync: BC,BC,BC,AB,BC,BC,BC -> active stays 0, no val_outN; a 4th consecutive BC -> active=1.
REQ-033 Realignment: in ACTIVE, bytes 11,22,BC,33 -> out0=11, out1=22, then out0=33; no forwarding of BC.
REQ-034 Loss of sync: in ACTIVE, 4 strobes with sym_err=1 -> sync_lost one-cycle pulse, active=0, no val_outN during those strobes; 3 errored bytes then 8'h55 clean -> stays ACTIVE, 55 forwarded.
REQ-035 Async reset: assert reset_L between clock edges while in ACTIVE with lane_ptr=2 -> active=0, lane_ptr=0, all outputs zero before the next edge.
REQ-036 Rate: back-to-back byte_stb for 8 data bytes in ACTIVE -> 8 consecutive single val pulses cycling 0..3 twice.

Source files
------------

// File: rtl/rx_lane_sched.sv
// rx_lane_sched: comma-based sync FSM (HUNT/ACTIVE) that distributes clean
// data bytes round-robin across four lane registers with one-cycle valid pulses.
module rx_lane_sched #(
    parameter logic [7:0]  COMMA    = 8'hBC,
    parameter int unsigned SYNC_CNT = 4,
    parameter int unsigned LOSS_CNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset_L,
    input  logic [7:0] byte_in,
    input  logic       byte_stb,
    input  logic       sym_err,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic [7:0] out2,
    output logic [7:0] out3,
    output logic       val_out0,
    output logic       val_out1,
    output logic       val_out2,
    output logic       val_out3,
    output logic       active,
    output logic [1:0] lane_ptr,
    output logic       sync_lost
);

    localparam int unsigned BCW = $clog2(SYNC_CNT + 1);
    localparam int unsigned ECW = $clog2(LOSS_CNT + 1);

    typedef enum logic {
        HUNT   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [BCW-1:0] bc_cnt_q, bc_cnt_d;
    logic [ECW-1:0] err_cnt_q, err_cnt_d;
    logic [1:0]     lane_q, lane_d;
    logic [7:0]     out_q [4];
    logic [3:0]     val_q, val_d;
    logic           sync_lost_q, sync_lost_d;
    logic           wr_en;
    logic           err_at_limit;

    // The errored strobe that would push err_cnt to LOSS_CNT drops sync.
    assign err_at_limit = (err_cnt_q >= ECW'(LOSS_CNT - 1));

    // State register: FSM state, counters and lane pointer.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q   <= HUNT;
            bc_cnt_q  <= '0;
            err_cnt_q <= '0;
            lane_q    <= '0;
        end else begin
            state_q   <= state_d;
            bc_cnt_q  <= bc_cnt_d;
            err_cnt_q <= err_cnt_d;
            lane_q    <= lane_d;
        end
    end

    // Next-state logic: only strobed bytes move counters, pointer or state.
    always_comb begin
        state_d   = state_q;
        bc_cnt_d  = bc_cnt_q;
        err_cnt_d = err_cnt_q;
        lane_d    = lane_q;
        if (byte_stb) begin
            unique case (state_q)
                HUNT: begin
                    if (!sym_err && byte_in == COMMA) begin
                        if (bc_cnt_q >= BCW'(SYNC_CNT - 1)) begin
                            bc_cnt_d  = BCW'(SYNC_CNT);
                            state_d   = ACTIVE;
                            lane_d    = '0;
                            err_cnt_d = '0;
                        end else begin
                            bc_cnt_d = bc_cnt_q + BCW'(1);
                        end
                    end else begin
                        bc_cnt_d = '0;
                    end
                end
                ACTIVE: begin
                    if (sym_err) begin
                        if (err_at_limit) begin
                            state_d   = HUNT;
                            bc_cnt_d  = '0;
                            err_cnt_d = '0;
                            lane_d    = '0;
                        end else begin
                            err_cnt_d = err_cnt_q + ECW'(1);
                            lane_d    = lane_q + 2'd1;
                        end
                    end else if (byte_in == COMMA) begin
                        lane_d    = '0;
                        err_cnt_d = '0;
                    end else begin
                        lane_d    = lane_q + 2'd1;
                        err_cnt_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output decode: lane write/valid pulse and sync-loss pulse for the next cycle.
    always_comb begin
        wr_en       = 1'b0;
        val_d       = '0;
        sync_lost_d = 1'b0;
        if (byte_stb && state_q == ACTIVE) begin
            if (sym_err) begin
                sync_lost_d = err_at_limit;
            end else if (byte_in != COMMA) begin
                wr_en         = 1'b1;
                val_d[lane_q] = 1'b1;
            end
        end
    end

    // Output registers: lane data holds unless written, pulses last one cycle.
    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            for (int unsigned i = 0; i < 4; i++) begin
                out_q[i] <= '0;
            end
            val_q       <= '0;
            sync_lost_q <= 1'b0;
        end else begin
            val_q       <= val_d;
            sync_lost_q <= sync_lost_d;
            if (wr_en) begin
                out_q[lane_q] <= byte_in;
            end
        end
    end

    assign out0      = out_q[0];
    assign out1      = out_q[1];
    assign out2      = out_q[2];
    assign out3      = out_q[3];
    assign val_out0  = val_q[0];
    assign val_out1  = val_q[1];
    assign val_out2  = val_q[2];
    assign val_out3  = val_q[3];
    assign active    = (state_q == ACTIVE);
    assign lane_ptr  = lane_q;
    assign sync_lost = sync_lost_q;

endmodule

// File: tb/tb_rx_lane_sched.sv
// Testbench for rx_lane_sched: directed scenarios plus randomized traffic
// compared against a behavioural model of the lane scheduler.
module tb_rx_lane_sched;

    localparam logic [7:0] COMMA    = 8'hBC;
    localparam int         SYNC_CNT = 4;
    localparam int         LOSS_CNT = 4;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] byte_in = '0;
    logic       byte_stb = 1'b0;
    logic       sym_err = 1'b0;
    logic [7:0] out0, out1, out2, out3;
    logic       val_out0, val_out1, val_out2, val_out3;
    logic       active;
    logic [1:0] lane_ptr;
    logic       sync_lost;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    int         m_active;
    int         m_bc;
    int         m_err;
    int         m_lane;
    int         m_val;
    int         m_lost;
    logic [7:0] m_out [4];

    rx_lane_sched #(
        .COMMA   (COMMA),
        .SYNC_CNT(SYNC_CNT),
        .LOSS_CNT(LOSS_CNT)
    ) dut (
        .clk_32f  (clk_32f),
        .reset_L  (reset_L),
        .byte_in  (byte_in),
        .byte_stb (byte_stb),
        .sym_err  (sym_err),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3),
        .val_out0 (val_out0),
        .val_out1 (val_out1),
        .val_out2 (val_out2),
        .val_out3 (val_out3),
        .active   (active),
        .lane_ptr (lane_ptr),
        .sync_lost(sync_lost)
    );

    always #5 clk_32f = ~clk_32f;

    function automatic logic [39:0] dut_vec();
        return {active, lane_ptr, sync_lost, val_out3, val_out2, val_out1, val_out0,
                out3, out2, out1, out0};
    endfunction

    function automatic logic [39:0] exp_vec();
        logic [3:0] v;
        logic [1:0] lp;
        v  = (m_val >= 0) ? (4'b0001 << m_val) : 4'b0000;
        lp = m_lane[1:0];
        return {(m_active != 0), lp, (m_lost != 0), v, m_out[3], m_out[2], m_out[1], m_out[0]};
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_bc     = 0;
        m_err    = 0;
        m_lane   = 0;
        m_val    = -1;
        m_lost   = 0;
        for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
    endtask

    // Applies one cycle of input, then advances the model by the same cycle.
    task automatic drive(input logic stb, input logic [7:0] b, input logic e);
        byte_stb = stb;
        byte_in  = b;
        sym_err  = e;
        @(posedge clk_32f);
        #1;
        m_val  = -1;
        m_lost = 0;
        if (stb) begin
            if (m_active == 0) begin
                if (b == COMMA && !e) begin
                    m_bc = (m_bc + 1 > SYNC_CNT) ? SYNC_CNT : m_bc + 1;
                    if (m_bc == SYNC_CNT) begin
                        m_active = 1;
                        m_lane   = 0;
                        m_err    = 0;
                    end
                end else begin
                    m_bc = 0;
                end
            end else if (e) begin
                m_lane = (m_lane + 1) % 4;
                m_err  = m_err + 1;
                if (m_err >= LOSS_CNT) begin
                    m_active = 0;
                    m_lost   = 1;
                    m_bc     = 0;
                    m_err    = 0;
                    m_lane   = 0;
                end
            end else if (b == COMMA) begin
                m_lane = 0;
                m_err  = 0;
            end else begin
                m_out[m_lane] = b;
                m_val  = m_lane;
                m_lane = (m_lane + 1) % 4;
                m_err  = 0;
            end
        end
        byte_stb = 1'b0;
    endtask

    task automatic do_reset();
        byte_stb = 1'b0;
        sym_err  = 1'b0;
        reset_L  = 1'b0;
        #1;
        model_reset();
        @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        byte_stb = 1'b0;
        reset_L  = 1'b0;
        #2;
        model_reset();
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), exp_vec());
        end
        @(posedge clk_32f);
        #1;
        reset_L = 1'b1;
    endtask

    task automatic test_sync_acq();
        logic [7:0] seq [9] = '{8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hAB, 8'hAB, 8'hAB, 8'hAB, 8'hAB};
        int         exp_lane_pulse [9] = '{-1, -1, -1, -1, 0, 1, 2, 3, 0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, seq[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec() || m_val != exp_lane_pulse[i]) begin
                tests_failed++;
                $display("FAIL sync_acq[%0d]: got %h expected %h (model lane %0d, listed %0d)",
                         i, dut_vec(), exp_vec(), m_val, exp_lane_pulse[i]);
            end
        end
        tests_run++;
        if (lane_ptr !== 2'd1 || active !== 1'b1 || out0 !== 8'hAB || out3 !== 8'hAB) begin
            tests_failed++;
            $display("FAIL sync_acq_end: got lane_ptr=%0d active=%b out0=%h out3=%h expected 1 1 ab ab",
                     lane_ptr, active, out0, out3);
        end
    endtask

    task automatic test_no_sync();
        logic [7:0] seq [8] = '{8'hBC, 8'hBC, 8'hBC, 8'hAB, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, seq[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec() || active !== (i == 7)) begin
                tests_failed++;
                $display("FAIL no_sync[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        // comma with sym_err in HUNT must break the run as well
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, COMMA, (i == 2));
            tests_run++;
            if (dut_vec() !== exp_vec() || active !== (i == 6 || i == 7)) begin
                tests_failed++;
                $display("FAIL errored_comma[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_realign();
        logic [7:0] seq [4] = '{8'h11, 8'h22, 8'hBC, 8'h33};
        do_reset();
        for (int i = 0; i < SYNC_CNT; i++) drive(1'b1, COMMA, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seq[i], 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL realign[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        tests_run++;
        if (out0 !== 8'h33 || out1 !== 8'h22 || lane_ptr !== 2'd1) begin
            tests_failed++;
            $display("FAIL realign_end: got out0=%h out1=%h lane=%0d expected 33 22 1", out0, out1, lane_ptr);
        end
    endtask

    task automatic test_loss();
        do_reset();
        for (int i = 0; i < SYNC_CNT; i++) drive(1'b1, COMMA, 1'b0);
        drive(1'b1, 8'h77, 1'b0);
        for (int i = 0; i < LOSS_CNT; i++) begin
            drive(1'b1, 8'h5A, 1'b1);
            tests_run++;
            if (dut_vec() !== exp_vec() || sync_lost !== (i == LOSS_CNT - 1)) begin
                tests_failed++;
                $display("FAIL loss[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        drive(1'b0, 8'h00, 1'b0);
        tests_run++;
        if (dut_vec() !== exp_vec() || sync_lost !== 1'b0 || active !== 1'b0) begin
            tests_failed++;
            $display("FAIL loss_after: got %h expected %h", dut_vec(), exp_vec());
        end
        // three errors then a clean byte keeps sync
        for (int i = 0; i < SYNC_CNT; i++) drive(1'b1, COMMA, 1'b0);
        for (int i = 0; i < LOSS_CNT - 1; i++) drive(1'b1, 8'h00, 1'b1);
        drive(1'b1, 8'h55, 1'b0);
        tests_run++;
        if (dut_vec() !== exp_vec() || active !== 1'b1 || out3 !== 8'h55 || val_out3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL near_loss: got %h expected %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < SYNC_CNT; i++) drive(1'b1, COMMA, 1'b0);
        drive(1'b1, 8'hC1, 1'b0);
        drive(1'b1, 8'hC2, 1'b0);
        tests_run++;
        if (lane_ptr !== 2'd2 || val_out1 !== 1'b1 || dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL pre_async: got %h expected %h", dut_vec(), exp_vec());
        end
        // strobe pending for the next edge, reset lands between edges
        byte_stb = 1'b1;
        byte_in  = 8'hC3;
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL async_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        @(posedge clk_32f);
        #1;
        tests_run++;
        if (dut_vec() !== exp_vec()) begin
            tests_failed++;
            $display("FAIL reset_inflight: got %h expected %h", dut_vec(), exp_vec());
        end
        byte_stb = 1'b0;
        reset_L  = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < SYNC_CNT; i++) drive(1'b1, COMMA, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0);
            tests_run++;
            if (dut_vec() !== exp_vec() || m_val != (i % 4)) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int r;
        logic [7:0] b;
        logic       e;
        logic       s;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            s = (r < 75);
            b = (r % 3 == 0) ? COMMA : 8'($urandom);
            e = ($urandom_range(0, 99) < 12);
            // bias toward long comma runs so sync is acquired regularly
            if (m_active == 0 && $urandom_range(0, 3) != 0) begin
                b = COMMA;
                e = 1'b0;
            end
            drive(s, b, e);
            tests_run++;
            if (dut_vec() !== exp_vec()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sync_acq();
        test_no_sync();
        test_realign();
        test_loss();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
